vjtag_cmd_sequencer: RTL and testbench
======================================

VJTAG_CMD_SEQUENCER -- requirements
Module: vjtag_cmd_sequencer

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state rising-edge clk except async reset.
REQ-002 SHALL have port aclr  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port byte_in  input  8  byte from the vJTAG update register; stable whenever byte_tgl is stable.
REQ-004 SHALL have port byte_tgl  input  1  toggles once per vJTAG update-DR (tck domain); each edge = one new byte.
REQ-005 SHALL have port wr_ready  input  1  downstream register-write accept.
REQ-006 SHALL have port wr_valid  output  1  write request.
REQ-007 SHALL have port wr_addr  output  4  target register address.
REQ-008 SHALL have port wr_data  output  16  target register data.
REQ-009 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 SHALL have port err_cnt  output  8  saturating protocol-error count.

Function
REQ-011 SHALL pass byte_tgl through a 2-flop synchronizer plus 1 edge flop; byte event = sync2 XOR edge; byte_in sampled into the datapath on that event; latency from byte_tgl edge to event is 3 clk.
REQ-012 SHALL decode the header byte as op = [7:6], cnt = [5:4] (words = cnt+1, 1..4), addr = [3:0].
REQ-013 SHALL use FSM states IDLE, DLO, DHI, WR.
REQ-014 IDLE, byte event: op 00 = nop, stay IDLE; op 11 = clear err_cnt, stay IDLE; op 01 (fixed addr) or op 10 (incrementing addr) = latch addr, cnt and op, go DLO.
REQ-015 DLO, byte event: latch wr_data[7:0], go DHI. DHI, byte event: latch wr_data[15:8], go WR.
REQ-016 WR: wr_valid = 1; wr_addr/wr_data held stable until a clk edge with wr_valid && wr_ready.
REQ-017 On accept: if words remain, decrement the remaining count, go DLO (op 10: addr increments mod 16, 15 wraps to 0; op 01: addr unchanged); otherwise go IDLE.
REQ-018 wr_valid SHALL deassert the cycle after accept; there are never back-to-back valid cycles.
REQ-019 A byte event in WR SHALL be dropped and err_cnt incremented; state and outputs unchanged.
REQ-020 err_cnt SHALL saturate at 255.
REQ-021 If an op-11 clear and an increment coincide, the clear SHALL win.

Reset
REQ-022 On aclr: state IDLE; wr_valid, wr_addr, wr_data and err_cnt = 0; synchronizer and edge flops = 0; any partial packet discarded; wr_valid drops asynchronously.
REQ-023 For 3 clk after aclr release, the edge flop SHALL track sync2 with byte events suppressed, so a byte_tgl level of 1 at release does not create a spurious byte.

Configuration
REQ-024 With macro VJTAG_SEQ_TIMEOUT_EN defined, a 16-bit idle counter SHALL run in DLO/DHI, clear on each byte event, and at 65535 force IDLE and increment err_cnt.
REQ-025 Without VJTAG_SEQ_TIMEOUT_EN, there SHALL be no counter and DLO/DHI wait indefinitely.

Verification
REQ-026 Bytes 0x43,0x34,0x12 with wr_ready=1 -> one write, addr 3, data 0x1234; busy low after accept.
REQ-027 Bytes 0xBE,(0x01,0x00)x4 -> writes to addr 14,15,0,1, each data 0x0001 (address wrap).
REQ-028 Header 0x45, bytes 0xCD,0xAB, wr_ready=0 for 10 clk, extra byte 0x99 sent -> valid held, addr 5/data 0xABCD stable, err_cnt=1, write completes when wr_ready=1.
REQ-029 300 overrun bytes, then 0xC0 -> err_cnt stops at 255, then reads 0.
REQ-030 aclr pulse in DHI with byte_tgl=1 -> IDLE, outputs 0, no spurious byte; next 0x41,0x00,0x00 -> write addr 1. With VJTAG_SEQ_TIMEOUT_EN, stall in DLO 65535 clk -> IDLE, err_cnt+1.

Source files
------------

// File: rtl/vjtag_cmd_sequencer.sv
// Turns a byte stream from a virtual-JTAG update register into 16-bit register writes.
// Optional macro VJTAG_SEQ_TIMEOUT_EN adds an idle timeout while waiting for data bytes.
module vjtag_cmd_sequencer (
  input  logic        clk,
  input  logic        aclr,
  input  logic [7:0]  byte_in,
  input  logic        byte_tgl,
  input  logic        wr_ready,
  output logic        wr_valid,
  output logic [3:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam int unsigned ERR_W = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_DLO, ST_DHI, ST_WR} state_t;

  state_t     state, next_state;
  logic       tgl_s1, tgl_s2, tgl_edge;
  logic [1:0] arm_cnt;
  logic       byte_evt_c;
  logic       tmo_c;
  logic [1:0] rem;
  logic       op_inc;
  logic       hdr_ld, lo_ld, hi_ld, acc, err_inc, err_clr;

  // Toggle synchronizer; events stay masked for 3 clk after reset release
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      tgl_s1   <= 1'b0;
      tgl_s2   <= 1'b0;
      tgl_edge <= 1'b0;
      arm_cnt  <= 2'd0;
    end else begin
      tgl_s1   <= byte_tgl;
      tgl_s2   <= tgl_s1;
      tgl_edge <= tgl_s2;
      if (arm_cnt != 2'd3) arm_cnt <= arm_cnt + 2'd1;
    end
  end

  assign byte_evt_c = (tgl_s2 ^ tgl_edge) && (arm_cnt == 2'd3);

`ifdef VJTAG_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = 16;
  logic [TMO_W-1:0] idle_cnt;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr)
      idle_cnt <= '0;
    else if ((state == ST_DLO || state == ST_DHI) && !byte_evt_c && !tmo_c)
      idle_cnt <= idle_cnt + TMO_W'(1);
    else
      idle_cnt <= '0;
  end

  assign tmo_c = (state == ST_DLO || state == ST_DHI) && !byte_evt_c &&
                 (idle_cnt == {TMO_W{1'b1}});
`else
  assign tmo_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) state <= ST_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (byte_evt_c && (byte_in[7:6] == 2'b01 || byte_in[7:6] == 2'b10))
                 next_state = ST_DLO;
      ST_DLO:  if (byte_evt_c) next_state = ST_DHI;
               else if (tmo_c) next_state = ST_IDLE;
      ST_DHI:  if (byte_evt_c) next_state = ST_WR;
               else if (tmo_c) next_state = ST_IDLE;
      ST_WR:   if (wr_ready) next_state = (rem != 2'd0) ? ST_DLO : ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    hdr_ld  = 1'b0;
    lo_ld   = 1'b0;
    hi_ld   = 1'b0;
    acc     = 1'b0;
    err_inc = 1'b0;
    err_clr = 1'b0;
    case (state)
      ST_IDLE: if (byte_evt_c) begin
                 err_clr = (byte_in[7:6] == 2'b11);
                 hdr_ld  = (byte_in[7:6] == 2'b01 || byte_in[7:6] == 2'b10);
               end
      ST_DLO:  begin lo_ld = byte_evt_c; err_inc = tmo_c; end
      ST_DHI:  begin hi_ld = byte_evt_c; err_inc = tmo_c; end
      ST_WR:   begin err_inc = byte_evt_c; acc = wr_ready; end
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wr_valid <= 1'b0;
      busy     <= 1'b0;
      wr_addr  <= 4'd0;
      wr_data  <= 16'd0;
      err_cnt  <= '0;
      rem      <= 2'd0;
      op_inc   <= 1'b0;
    end else begin
      wr_valid <= (next_state == ST_WR);
      busy     <= (next_state != ST_IDLE);
      if (hdr_ld) begin
        wr_addr <= byte_in[3:0];
        rem     <= byte_in[5:4];
        op_inc  <= byte_in[7];
      end
      if (lo_ld) wr_data[7:0]  <= byte_in;
      if (hi_ld) wr_data[15:8] <= byte_in;
      if (acc && rem != 2'd0) begin
        rem <= rem - 2'd1;
        if (op_inc) wr_addr <= wr_addr + 4'd1;
      end
      if (err_clr)
        err_cnt <= '0;
      else if (err_inc && err_cnt != {ERR_W{1'b1}})
        err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_vjtag_cmd_sequencer.sv
// Self-checking bench for vjtag_cmd_sequencer: vector table plus hand sequences, write scoreboard.
module tb_vjtag_cmd_sequencer;

  logic        clk = 1'b0;
  logic        aclr;
  logic [7:0]  byte_in;
  logic        byte_tgl;
  logic        wr_ready;
  logic        wr_valid;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic [7:0]  err_cnt;

  typedef struct {
    logic [7:0]  hdr;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [3:0]  addr;
    logic [15:0] data;
  } vec_t;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  vec_t vecs[4];
  int   n_checks = 0;
  int   n_fail   = 0;

  vjtag_cmd_sequencer dut (
    .clk      (clk),
    .aclr     (aclr),
    .byte_in  (byte_in),
    .byte_tgl (byte_tgl),
    .wr_ready (wr_ready),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    byte_in  = b;
    byte_tgl = ~byte_tgl;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [15:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  // Scoreboard: every accepted write is popped and compared
  always @(negedge clk) begin
    if (!aclr && wr_valid && wr_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
        check("wr_data", 32'(wr_data), 32'(mon_e.data));
      end
    end
  end

  initial begin
    vecs[0] = '{hdr: 8'h43, lo: 8'h34, hi: 8'h12, addr: 4'd3,  data: 16'h1234};
    vecs[1] = '{hdr: 8'h40, lo: 8'hFF, hi: 8'hFF, addr: 4'd0,  data: 16'hFFFF};
    vecs[2] = '{hdr: 8'h4F, lo: 8'h00, hi: 8'h80, addr: 4'd15, data: 16'h8000};
    vecs[3] = '{hdr: 8'h8A, lo: 8'h5A, hi: 8'hA5, addr: 4'd10, data: 16'hA55A};

    aclr = 1'b1; byte_tgl = 1'b0; byte_in = 8'h00; wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_wr_addr",  32'(wr_addr),  32'd0);
    check("rst_wr_data",  32'(wr_data),  32'd0);
    check("rst_err_cnt",  32'(err_cnt),  32'd0);
    aclr = 1'b0;
    repeat (5) @(posedge clk);

    // Byte event latency: header acted on at the third clk edge after the toggle
    @(posedge clk); #1;
    byte_in = 8'h41; byte_tgl = ~byte_tgl;
    @(posedge clk); #1; check("lat_edge1", 32'(busy), 32'd0);
    @(posedge clk); #1; check("lat_edge2", 32'(busy), 32'd0);
    @(posedge clk); #1; check("lat_edge3", 32'(busy), 32'd1);
    push(4'd1, 16'h0000);
    send_byte(8'h00);
    send_byte(8'h00);
    check("lat_pkt_idle", 32'(busy), 32'd0);

    send_byte(8'h00);
    check("nop_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 4; i++) begin
      push(vecs[i].addr, vecs[i].data);
      send_byte(vecs[i].hdr);
      send_byte(vecs[i].lo);
      send_byte(vecs[i].hi);
      check("vec_busy_after", 32'(busy), 32'd0);
    end

    // Incrementing burst wrapping 15 -> 0
    push(4'd14, 16'h0001); push(4'd15, 16'h0001);
    push(4'd0,  16'h0001); push(4'd1,  16'h0001);
    send_byte(8'hBE);
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h01);
      send_byte(8'h00);
    end
    check("wrap_busy", 32'(busy), 32'd0);

    // Fixed-address burst
    push(4'd7, 16'h2211); push(4'd7, 16'h4433);
    send_byte(8'h57);
    send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h44);
    check("fixed_busy", 32'(busy), 32'd0);

    // Backpressure with an overrun byte
    wr_ready = 1'b0;
    push(4'd5, 16'hABCD);
    send_byte(8'h45); send_byte(8'hCD); send_byte(8'hAB);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(wr_valid), 32'd1);
      check("hold_addr",  32'(wr_addr),  32'd5);
      check("hold_data",  32'(wr_data),  32'hABCD);
    end
    send_byte(8'h99);
    check("ovr_err",   32'(err_cnt),  32'd1);
    check("ovr_valid", 32'(wr_valid), 32'd1);
    check("ovr_data",  32'(wr_data),  32'hABCD);
    wr_ready = 1'b1;
    @(posedge clk); #1;
    check("post_acc_valid", 32'(wr_valid), 32'd0);
    check("post_acc_busy",  32'(busy),     32'd0);

    // err_cnt saturation, then clear
    wr_ready = 1'b0;
    push(4'd2, 16'h0000);
    send_byte(8'h42); send_byte(8'h00); send_byte(8'h00);
    for (int i = 0; i < 300; i++) send_byte(8'hFF);
    check("sat_err",   32'(err_cnt),  32'd255);
    check("sat_valid", 32'(wr_valid), 32'd1);
    wr_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("sat_busy", 32'(busy), 32'd0);
    send_byte(8'hC0);
    check("clr_err", 32'(err_cnt), 32'd0);

    // One more overrun so reset has a nonzero err_cnt to clear
    wr_ready = 1'b0;
    push(4'd6, 16'h5678);
    send_byte(8'h46); send_byte(8'h78); send_byte(8'h56); send_byte(8'hFF);
    check("err_one", 32'(err_cnt), 32'd1);
    wr_ready = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Reset mid-packet with byte_tgl high at release
    send_byte(8'h41); send_byte(8'h12);
    check("dhi_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    aclr = 1'b1;
    #1;
    check("arst_valid", 32'(wr_valid), 32'd0);
    check("arst_busy",  32'(busy),     32'd0);
    check("arst_data",  32'(wr_data),  32'd0);
    check("arst_err",   32'(err_cnt),  32'd0);
    byte_in  = 8'h45;
    byte_tgl = 1'b1;
    repeat (2) @(posedge clk); #1;
    aclr = 1'b0;
    repeat (10) @(posedge clk); #1;
    check("norel_busy", 32'(busy),    32'd0);
    check("norel_addr", 32'(wr_addr), 32'd0);
    push(4'd1, 16'h0000);
    send_byte(8'h41); send_byte(8'h00); send_byte(8'h00);
    check("post_rst_busy", 32'(busy), 32'd0);

`ifdef VJTAG_SEQ_TIMEOUT_EN
    send_byte(8'h41);
    check("tmo_dlo", 32'(busy), 32'd1);
    repeat (65540) @(posedge clk); #1;
    check("tmo_busy", 32'(busy),    32'd0);
    check("tmo_err",  32'(err_cnt), 32'd1);
`endif

    repeat (5) @(posedge clk); #1;
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
